// File: rtl/control_fsm_p.sv
// Parametrised processor control unit: owns the IR and T0..T3 step counter and
// decodes mv/mvi/add/sub/mvnz into datapath strobes plus Done/Busy/Illegal.
module control_fsm_p #(
  parameter  int REG_BITS = 3,
  parameter  int DW       = 16,
  localparam int IW       = 3 + 2*REG_BITS,
  localparam int NREG     = 2**REG_BITS
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [DW-1:0]   DIN,
  input  logic            G_nz,
  output logic [1:0]      Tstep,
  output logic [IW-1:0]   IR,
  output logic            IRin,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Done,
  output logic            Busy,
  output logic            Illegal
);
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  step_t               r_state, w_next;
  logic [IW-1:0]       r_ir;
  logic [2:0]          w_op;
  logic [NREG-1:0]     w_xdec, w_ydec;
  logic                w_unused_din;

  // Only the low IW bits of DIN are an instruction; the rest are don't-care here.
  assign w_unused_din = ^DIN;

  assign w_op   = r_ir[IW-1 -: 3];
  assign w_xdec = {{(NREG-1){1'b0}}, 1'b1} << r_ir[2*REG_BITS-1 -: REG_BITS];
  assign w_ydec = {{(NREG-1){1'b0}}, 1'b1} << r_ir[REG_BITS-1:0];

  assign Tstep = r_state;
  assign IR    = r_ir;
  assign Busy  = (r_state != T0);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (IRin) r_ir <= DIN[IW-1:0];
    end
  end

  always_comb begin
    w_next  = r_state;
    IRin    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Rin     = '0;
    Rout    = '0;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (r_state)
      T0: begin
        // IRin reflects the actual IR load, which reset blocks.
        IRin   = Run & Resetn;
        w_next = Run ? T1 : T0;
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            Rout = w_ydec;
            Rin  = w_xdec;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_xdec;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout = w_xdec;
            Ain  = 1'b1;
          end
          OP_MVNZ: begin
            Done = 1'b1;
            if (G_nz) begin
              Rout = w_ydec;
              Rin  = w_xdec;
            end
          end
          default: begin
            Illegal = 1'b1;
            Done    = 1'b1;
          end
        endcase
        w_next = Done ? T0 : T2;
      end
      T2: begin
        Rout   = w_ydec;
        Gin    = 1'b1;
        AddSub = (w_op == OP_SUB);
        w_next = T3;
      end
      T3: begin
        Gout   = 1'b1;
        Rin    = w_xdec;
        Done   = 1'b1;
        w_next = T0;
      end
      default: w_next = T0;
    endcase
  end
endmodule

// File: tb/tb_control_fsm_p.sv
// Directed + randomized bench for control_fsm_p; expected strobes come from an
// instruction-level model of the opcode table.
module tb_control_fsm_p;
  logic        Clock = 1'b0;
  logic        Resetn, Run, G_nz;
  logic [15:0] DIN;
  logic [1:0]  Tstep;
  logic [8:0]  IR;
  logic        IRin, Ain, Gin, AddSub, DINout, Gout, Done, Busy, Illegal;
  logic [7:0]  Rin, Rout;

  typedef struct packed {
    logic [1:0] t;
    logic       irin, ain, gin, addsub;
    logic [7:0] rin, rout;
    logic       dinout, gout, done, busy, illegal;
  } obs_t;

  obs_t obs;
  int   vecs = 0;
  int   miss = 0;

  control_fsm_p #(.REG_BITS(3), .DW(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .G_nz(G_nz),
    .Tstep(Tstep), .IR(IR), .IRin(IRin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout), .Done(Done),
    .Busy(Busy), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  always_comb obs = {Tstep, IRin, Ain, Gin, AddSub, Rin, Rout, DINout, Gout, Done, Busy, Illegal};

  // Cycles an instruction occupies after T0.
  function automatic int nsteps(input int op);
    return (op == 2 || op == 3) ? 3 : 1;
  endfunction

  // Expected outputs for a given instruction at a given step.
  function automatic obs_t model(input int op, input int x, input int y,
                                 input int step, input bit gnz, input bit run);
    obs_t o;
    o      = '0;
    o.t    = 2'(step);
    o.busy = (step != 0);
    if (step == 0) begin
      o.irin = run;
      return o;
    end
    case (op)
      0: begin o.rout = 8'(1 << y); o.rin = 8'(1 << x); o.done = 1; end
      1: begin o.dinout = 1; o.rin = 8'(1 << x); o.done = 1; end
      2, 3: begin
        if (step == 1) begin o.rout = 8'(1 << x); o.ain = 1; end
        if (step == 2) begin o.rout = 8'(1 << y); o.gin = 1; o.addsub = (op == 3); end
        if (step == 3) begin o.gout = 1; o.rin = 8'(1 << x); o.done = 1; end
      end
      4: begin
        o.done = 1;
        if (gnz) begin o.rout = 8'(1 << y); o.rin = 8'(1 << x); end
      end
      default: begin o.illegal = 1; o.done = 1; end
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    vecs++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_ir(input string tag, input logic [8:0] o, input logic [8:0] e);
    vecs++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s IR observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered just after a rising edge with the DUT in T0; leaves it the same way.
  task automatic do_instr(input string tag, input logic [15:0] din,
                          input logic [15:0] imm, input bit gnz);
    int op, x, y;
    op = int'(din[8:6]); x = int'(din[5:3]); y = int'(din[2:0]);
    Run = 1'b1; DIN = din; G_nz = 1'($urandom);
    @(negedge Clock) chk({tag, "_T0"}, obs, model(op, x, y, 0, 0, 1));
    @(posedge Clock) #1;
    for (int s = 1; s <= nsteps(op); s++) begin
      Run  = 1'($urandom);
      DIN  = (op == 1 && s == 1) ? imm : 16'($urandom);
      G_nz = gnz;
      @(negedge Clock);
      if (s == 1) chk_ir({tag, "_IR"}, IR, din[8:0]);
      chk($sformatf("%s_T%0d", tag, s), obs, model(op, x, y, s, gnz, 0));
      @(posedge Clock) #1;
    end
  endtask

  task automatic idle(input string tag);
    Run = 1'b0; DIN = 16'($urandom); G_nz = 1'($urandom);
    @(negedge Clock) chk(tag, obs, model(0, 0, 0, 0, 0, 0));
    @(posedge Clock) #1;
  endtask

  initial begin
    logic [15:0] d;
    Resetn = 1'b0; Run = 1'b1; DIN = 16'h0015; G_nz = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    @(negedge Clock);
    chk("reset", obs, '0);
    chk_ir("reset", IR, 9'h000);
    @(posedge Clock) #1;
    Resetn = 1'b1;

    idle("idle0");
    do_instr("mv_r2_r5",   16'h0015, 16'h0000, 0);
    idle("idle1");
    do_instr("mvi_r3",     16'h0058, 16'h00A5, 0);
    do_instr("sub_r1_r6",  16'h00CE, 16'h0000, 0);
    do_instr("add_r1_r6",  16'h008E, 16'h0000, 1);
    do_instr("mvnz_g0",    16'h0120, 16'h0000, 0);
    do_instr("mvnz_g1",    16'h0120, 16'h0000, 1);
    do_instr("illegal7",   16'h01C0, 16'h0000, 0);
    do_instr("illegal5",   16'h0140, 16'h0000, 1);
    do_instr("illegal6",   16'h0180, 16'h0000, 0);
    do_instr("mv_r4_r4",   16'h0024, 16'h0000, 0);
    do_instr("upper_dc",   16'hFE15, 16'h0000, 0);
    idle("idle2");

    // Random instruction stream, mostly back-to-back with occasional idle gaps.
    for (int i = 0; i < 120; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) idle($sformatf("ridle%0d", i));
      do_instr($sformatf("rnd%0d", i), d, 16'($urandom), 1'($urandom));
    end

    // Reset landing in T2 of an add.
    Run = 1'b1; DIN = 16'h008E;
    @(posedge Clock) #1;
    Run = 1'b0;
    @(negedge Clock) chk("rst_add_T1", obs, model(2, 1, 6, 1, 0, 0));
    @(posedge Clock) #1;
    Resetn = 1'b0;
    @(posedge Clock) #1;
    @(negedge Clock);
    chk("rst_mid", obs, '0);
    chk_ir("rst_mid", IR, 9'h000);
    Run = 1'b1; DIN = 16'h0015;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock) #1;
      @(negedge Clock);
      chk($sformatf("rst_run%0d", i), obs, '0);
      chk_ir($sformatf("rst_run%0d", i), IR, 9'h000);
    end
    @(posedge Clock) #1;
    Resetn = 1'b1;
    do_instr("post_rst_mv", 16'h0015, 16'h0000, 0);
    idle("idle_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
